idct_t_compute: RTL and testbench

First-pass IDCT matrix stage: for one 8x8 block it computes T = S' x C, where S' is the dequantized coefficient block and C is the fixed Q12 cosine matrix. It streams S' from the coefficient RAM, multiplies each value by a coefficient from the combinational lookup, accumulates eight products per output and writes 64 scaled T values to the T RAM. It sits between the dequantizer's S' buffer and the second-pass (S = C^T x T) stage, and is kicked by the top-level decode FSM once per block.

---
 rtl/idct_pkg.sv | 20 ++
 rtl/get_c_values.sv | 65 ++++++
 rtl/idct_t_compute.sv | 125 ++++++++++++
 tb/tb_idct_t_compute.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// idct_pkg: types and constants shared by the IDCT matrix stages.
//   idct_state_t : block-level FSM states (IDLE/RUN/DRAIN/DONE)
//   C_FRAC_BITS  : fractional bits of the Q12 cosine coefficients
//   C_WIDTH      : signed width of one cosine coefficient
//   blk_addr_t   : 6-bit row-major address into an 8x8 block
package idct_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } idct_state_t;

  localparam int C_FRAC_BITS = 12;
  localparam int C_WIDTH     = 13;

  typedef logic [5:0] blk_addr_t;

endpackage

// File: rtl/get_c_values.sv
// get_c_values: combinational Q12 IDCT cosine lookup.
//   i : sample index (0..7)
//   j : frequency index (0..7)
//   c : signed C(i,j); 1448 (4096/sqrt(8)) for j=0, otherwise
//       2048*cos((2i+1)*j*pi/16) truncated toward zero
module get_c_values
  import idct_pkg::*;
(
  input  logic [2:0]                i,
  input  logic [2:0]                j,
  output logic signed [C_WIDTH-1:0] c
);

  localparam logic [C_WIDTH-1:0] HALF_SCALE = C_WIDTH'(1 << (C_FRAC_BITS - 1));
  localparam logic [C_WIDTH-1:0] DC_VALUE   = 13'd1448;

  // |cos(a*pi/16)| scaled by 2048 for the first quadrant, a = 0..8.
  function automatic logic [C_WIDTH-1:0] cos_mag(input logic [4:0] a);
    case (a)
      5'd0:    cos_mag = HALF_SCALE;
      5'd1:    cos_mag = 13'd2008;
      5'd2:    cos_mag = 13'd1892;
      5'd3:    cos_mag = 13'd1702;
      5'd4:    cos_mag = 13'd1448;
      5'd5:    cos_mag = 13'd1137;
      5'd6:    cos_mag = 13'd783;
      5'd7:    cos_mag = 13'd399;
      default: cos_mag = '0;
    endcase
  endfunction

  logic [4:0]         phase;
  logic [4:0]         fold;
  logic               negate;
  logic [C_WIDTH-1:0] mag;

  // The angle (2i+1)*j*pi/16 only matters modulo 2*pi, i.e. modulo 32 in
  // units of pi/16, so a 5-bit product wraps exactly. The phase is then
  // folded into the first quadrant with the sign tracked separately.
  always_comb begin
    phase  = {1'b0, i, 1'b1} * {2'b00, j};
    fold   = phase;
    negate = 1'b0;
    if (phase < 5'd8) begin
      fold = phase;
    end else if (phase < 5'd16) begin
      fold   = 5'd16 - phase;
      negate = 1'b1;
    end else if (phase < 5'd24) begin
      fold   = phase - 5'd16;
      negate = 1'b1;
    end else begin
      fold = 5'd0 - phase;
    end
    mag = cos_mag(fold);
    if (j == 3'd0) begin
      c = $signed(DC_VALUE);
    end else if (negate) begin
      c = -$signed(mag);
    end else begin
      c = $signed(mag);
    end
  end

endmodule

// File: rtl/idct_t_compute.sv
// idct_t_compute: first IDCT pass, T = S' x C for one 8x8 block.
//   clk, rst : clock, asynchronous active-high reset
//   start    : one-cycle kick, accepted only when idle
//   busy     : high from the cycle after an accepted start through done
//   done     : one-cycle pulse after the last T write
//   s_addr   : S' RAM read address (r*8+k), data returns next cycle
//   s_rdata  : signed S' value for the previous s_addr
//   t_addr   : T RAM write address (r*8+n)
//   t_wdata  : signed T value, accumulated sum >>> SHIFT
//   t_we     : T RAM write enable, one cycle per output
module idct_t_compute
  import idct_pkg::*;
#(
  parameter int SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [5:0]         s_addr,
  input  logic signed [15:0] s_rdata,
  output logic [5:0]         t_addr,
  output logic signed [31:0] t_wdata,
  output logic               t_we
);

  idct_state_t state_q, state_d;
  logic [8:0]  rd_idx;
  logic        drain_q;

  // Read-side info for the idx whose S' value is on s_rdata this cycle.
  logic        v1;
  logic [2:0]  n1;
  logic [2:0]  k1;
  blk_addr_t   m1;

  logic signed [C_WIDTH-1:0] c_val;
  logic signed [31:0]        prod;
  logic signed [31:0]        mac_sum;
  logic signed [31:0]        acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rd_idx == 9'd511) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rd_idx wraps 511 -> 0 on leaving RUN, so it is already zero for the
  // next block and s_addr idles at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_idx  <= '0;
      drain_q <= 1'b0;
    end else begin
      if (state_q == RUN) begin
        rd_idx <= rd_idx + 9'd1;
      end
      drain_q <= (state_q == DRAIN) ? ~drain_q : 1'b0;
    end
  end

  // Each S' row is re-read once per output column: row from idx[8:6],
  // column k from idx[2:0].
  assign s_addr = {rd_idx[8:6], rd_idx[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      n1 <= '0;
      k1 <= '0;
      m1 <= '0;
    end else begin
      v1 <= (state_q == RUN);
      n1 <= rd_idx[5:3];
      k1 <= rd_idx[2:0];
      m1 <= rd_idx[8:3];
    end
  end

  get_c_values u_get_c_values (
    .i (n1),
    .j (k1),
    .c (c_val)
  );

  // k=0 loads the accumulator, so outputs need no clear cycle between them.
  assign prod    = 32'(s_rdata) * 32'(c_val);
  assign mac_sum = (k1 == 3'd0) ? prod : acc + prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      t_we    <= 1'b0;
      t_addr  <= '0;
      t_wdata <= '0;
    end else begin
      t_we <= 1'b0;
      if (v1) begin
        acc <= mac_sum;
        if (k1 == 3'd7) begin
          t_we    <= 1'b1;
          t_addr  <= m1;
          t_wdata <= mac_sum >>> SHIFT;
        end
      end
    end
  end

endmodule

// File: tb/tb_idct_t_compute.sv
// tb_idct_t_compute: self-checking bench for idct_t_compute.
// A floating-point cosine model gives the expected T block; a per-cycle
// checker compares busy/done/s_addr/t_we and every T write against it.
module tb_idct_t_compute;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               busy;
  logic               done;
  logic [5:0]         s_addr;
  logic signed [15:0] s_rdata = '0;
  logic [5:0]         t_addr;
  logic signed [31:0] t_wdata;
  logic               t_we;

  int     n_compared = 0;
  int     n_mismatched = 0;
  int     gcyc = 0;
  int     t0 = 0;
  logic   active = 1'b0;
  int     nwrites = 0;
  int     ndone = 0;
  int     s_mem [64];
  longint tref [64];
  longint cap [64];

  idct_t_compute #(.SHIFT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .s_addr  (s_addr),
    .s_rdata (s_rdata),
    .t_addr  (t_addr),
    .t_wdata (t_wdata),
    .t_we    (t_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) gcyc <= gcyc + 1;

  // S' RAM with one cycle of read latency.
  always @(posedge clk) s_rdata <= 16'(s_mem[s_addr]);

  task automatic checkOutput(input string name, input longint got, input longint exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int c_ref(input int i, input int j);
    real v;
    if (j == 0) return 1448;
    v = 2048.0 * $cos(real'((2 * i + 1) * j) * 3.141592653589793 / 16.0);
    return $rtoi(v);
  endfunction

  function automatic void compute_ref();
    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < 8; n++) begin
        longint sum = 0;
        for (int k = 0; k < 8; k++) begin
          sum += longint'(s_mem[r * 8 + k]) * longint'(c_ref(n, k));
        end
        tref[r * 8 + n] = sum >>> 8;
      end
    end
  endfunction

  function automatic void clear_mem();
    for (int a = 0; a < 64; a++) begin
      s_mem[a] = 0;
      cap[a]   = -999999;
    end
  endfunction

  // Per-cycle checker; cycle 0 is the cycle in which start is sampled.
  always @(negedge clk) begin
    int   rel;
    int   e_saddr;
    int   m;
    logic e_busy;
    logic e_done;
    logic e_we;
    rel     = active ? (gcyc - t0) : -1;
    e_busy  = (rel >= 1) && (rel <= 515);
    e_done  = (rel == 515);
    e_we    = (rel >= 10) && (rel <= 514) && (((rel - 10) % 8) == 0);
    e_saddr = ((rel >= 1) && (rel <= 512)) ? ((((rel - 1) >> 6) * 8) + ((rel - 1) & 7)) : 0;
    checkOutput($sformatf("busy@%0d", rel), busy, e_busy);
    checkOutput($sformatf("done@%0d", rel), done, e_done);
    checkOutput($sformatf("t_we@%0d", rel), t_we, e_we);
    checkOutput($sformatf("s_addr@%0d", rel), s_addr, e_saddr);
    if (t_we) nwrites++;
    if (done) ndone++;
    if (e_we && t_we) begin
      m = (rel - 10) / 8;
      checkOutput($sformatf("t_addr@%0d", rel), t_addr, m);
      checkOutput($sformatf("t_wdata[%0d]", m), t_wdata, tref[m]);
      cap[m] = t_wdata;
    end
  end

  // Runs one block from the current s_mem. extra_start pulses start again
  // at that relative cycle; reset_at aborts the block with rst there.
  task automatic applyStimulus(input int extra_start, input int reset_at);
    compute_ref();
    @(posedge clk);
    #1;
    start   = 1'b1;
    t0      = gcyc;
    active  = 1'b1;
    nwrites = 0;
    ndone   = 0;
    for (int rel = 1; rel <= 516; rel++) begin
      @(posedge clk);
      #1;
      start = (rel == extra_start);
      if (rel == reset_at) begin
        rst    = 1'b1;
        active = 1'b0;
        ndone  = 0;
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_t_we", t_we, 0);
        checkOutput("abort_t_addr", t_addr, 0);
        checkOutput("abort_t_wdata", t_wdata, 0);
        checkOutput("abort_s_addr", s_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        checkOutput("abort_no_done", ndone, 0);
        return;
      end
    end
    active = 1'b0;
    checkOutput("done_pulses", ndone, 1);
    checkOutput("write_count", nwrites, 64);
  endtask

  initial begin
    int ac_exp [8];
    ac_exp = '{2008, 1702, 1137, 399, -399, -1137, -1702, -2008};
    clear_mem();
    compute_ref();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_s_addr", s_addr, 0);
    checkOutput("reset_t_addr", t_addr, 0);
    checkOutput("reset_t_wdata", t_wdata, 0);
    checkOutput("reset_t_we", t_we, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] DC-only block, stray start in the DONE cycle");
    clear_mem();
    s_mem[0] = 256;
    applyStimulus(515, -1);
    for (int n = 0; n < 8; n++) checkOutput($sformatf("dc_T0_%0d", n), cap[n], 1448);
    checkOutput("dc_T1_0", cap[8], 0);
    checkOutput("dc_T7_7", cap[63], 0);

    $display("[TB] single AC block");
    clear_mem();
    s_mem[1] = 256;
    applyStimulus(-1, -1);
    for (int n = 0; n < 8; n++) checkOutput($sformatf("ac_T0_%0d", n), cap[n], ac_exp[n]);
    checkOutput("ac_T2_3", cap[19], 0);

    $display("[TB] negative floor block");
    clear_mem();
    for (int r = 0; r < 8; r++) s_mem[r * 8] = -1;
    applyStimulus(-1, -1);
    checkOutput("neg_T0_0", cap[0], -6);
    checkOutput("neg_T4_5", cap[37], -6);
    checkOutput("neg_T7_7", cap[63], -6);

    $display("[TB] full-scale row 3, stray start at cycle 200");
    clear_mem();
    for (int k = 0; k < 8; k++) s_mem[24 + k] = 32767;
    applyStimulus(200, -1);
    checkOutput("fs_T2_0", cap[16], 0);

    $display("[TB] mixed signed pattern");
    clear_mem();
    for (int a = 0; a < 64; a++) s_mem[a] = ((a * 1103 + 7) % 4001) - 2000;
    s_mem[9]  = -32768;
    s_mem[62] = 32767;
    applyStimulus(-1, -1);

    $display("[TB] reset abort at cycle 300");
    clear_mem();
    s_mem[0] = 256;
    applyStimulus(-1, 300);

    $display("[TB] DC-only block after abort");
    for (int a = 0; a < 64; a++) cap[a] = -999999;
    applyStimulus(-1, -1);
    for (int n = 0; n < 8; n++) checkOutput($sformatf("dc2_T0_%0d", n), cap[n], 1448);
    checkOutput("dc2_T5_1", cap[41], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
